// File: rtl/vfu_request_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : vfu_request_buffer_if
// Purpose  : Request, dispatch, completion and status signals between the
//            lane-slot arbiter, the request buffer and the VFU input port.
// Revision : 1.0 - initial release
// ============================================================================
interface vfu_request_buffer_if #(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 206,
  parameter int TAG_W     = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Arbiter -> buffer
  logic                 in_valid;
  logic                 in_ready;
  logic [PAYLOAD_W-1:0] in_bits;
  logic [TAG_W-1:0]     in_tag;
  // Buffer -> VFU
  logic                 out_valid;
  logic                 out_ready;
  logic [PAYLOAD_W-1:0] out_bits;
  logic [TAG_W-1:0]     out_tag;
  // VFU completions
  logic                 resp_valid;
  logic [TAG_W-1:0]     resp_tag;
  // Control and status
  logic                 flush;
  logic [CNT_W-1:0]     count;
  logic                 busy;
  logic                 resp_underflow;

  // Buffer side
  modport slave (
    input  in_valid, in_bits, in_tag, out_ready, resp_valid, resp_tag, flush,
    output in_ready, out_valid, out_bits, out_tag, count, busy, resp_underflow
  );

  // Driver side (arbiter / VFU / environment)
  modport master (
    output in_valid, in_bits, in_tag, out_ready, resp_valid, resp_tag, flush,
    input  in_ready, out_valid, out_bits, out_tag, count, busy, resp_underflow
  );
endinterface
`default_nettype wire

// File: rtl/vfu_request_buffer.sv
`default_nettype none
// ============================================================================
// Module   : vfu_request_buffer
// Purpose  : Registered FIFO between the slot arbiter and the VFU. Tracks
//            in-flight requests per tag and holds the head back while its
//            tag already has MAX_OUT requests outstanding at the VFU.
// Revision : 1.0 - initial release
// ============================================================================
module vfu_request_buffer #(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 206,
  parameter int TAG_W     = 2,
  parameter int MAX_OUT   = 2
) (
  input wire clock,
  input wire reset,          // asynchronous, active low
  vfu_request_buffer_if.slave bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int OCNT_W = $clog2(MAX_OUT + 1);
  localparam int NTAGS  = 1 << TAG_W;

  // Control state
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [OCNT_W-1:0] outstanding_q [NTAGS];
  logic [OCNT_W-1:0] outstanding_d [NTAGS];
  logic              resp_underflow_q, resp_underflow_d;

  // Storage (not reset)
  logic [PAYLOAD_W-1:0] mem_bits_q [DEPTH];
  logic [PAYLOAD_W-1:0] mem_bits_d [DEPTH];
  logic [TAG_W-1:0]     mem_tag_q  [DEPTH];
  logic [TAG_W-1:0]     mem_tag_d  [DEPTH];

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_stall;
  logic             w_push;
  logic             w_pop;
  logic             w_push_en;
  logic             w_pop_en;
  logic             w_busy;
  logic [TAG_W-1:0] w_head_tag;

  // Handshake and dispatch gating, all derived from registered state only
  always_comb begin
    w_head_tag  = mem_tag_q[rd_ptr_q];
    w_in_ready  = (count_q < CNT_W'(DEPTH));
    w_stall     = (outstanding_q[w_head_tag] == OCNT_W'(MAX_OUT));
    w_out_valid = (count_q != '0) && !w_stall;
    w_push      = bus.in_valid && w_in_ready;
    w_pop       = w_out_valid && bus.out_ready;
    // A flush discards any handshake of its own cycle
    w_push_en   = w_push && !bus.flush;
    w_pop_en    = w_pop && !bus.flush;
  end

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (w_pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({w_push_en, w_pop_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Per-tag in-flight counters; a dispatch and a completion of the same tag cancel
  always_comb begin
    logic inc;
    logic dec;
    inc              = 1'b0;
    dec              = 1'b0;
    resp_underflow_d = resp_underflow_q;
    for (int t = 0; t < NTAGS; t++) begin
      inc              = w_pop_en && (w_head_tag == TAG_W'(t));
      dec              = bus.resp_valid && (bus.resp_tag == TAG_W'(t));
      outstanding_d[t] = outstanding_q[t];
      if (inc && !dec) begin
        outstanding_d[t] = outstanding_q[t] + OCNT_W'(1);
      end else if (dec && !inc) begin
        if (outstanding_q[t] == '0) resp_underflow_d = 1'b1;
        else                        outstanding_d[t] = outstanding_q[t] - OCNT_W'(1);
      end
    end
  end

  // Busy whenever any tag has a request at the VFU
  always_comb begin
    w_busy = 1'b0;
    for (int t = 0; t < NTAGS; t++) begin
      w_busy = w_busy | (outstanding_q[t] != '0);
    end
  end

  // Storage write on accepted push
  always_comb begin
    mem_bits_d = mem_bits_q;
    mem_tag_d  = mem_tag_q;
    if (w_push_en) begin
      mem_bits_d[wr_ptr_q] = bus.in_bits;
      mem_tag_d[wr_ptr_q]  = bus.in_tag;
    end
  end

  // Control registers, cleared immediately by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      resp_underflow_q <= 1'b0;
      for (int t = 0; t < NTAGS; t++) outstanding_q[t] <= '0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      resp_underflow_q <= resp_underflow_d;
      for (int t = 0; t < NTAGS; t++) outstanding_q[t] <= outstanding_d[t];
    end
  end

  // Payload storage registers, intentionally without reset
  always_ff @(posedge clock) begin
    mem_bits_q <= mem_bits_d;
    mem_tag_q  <= mem_tag_d;
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.out_valid      = w_out_valid;
  assign bus.out_bits       = mem_bits_q[rd_ptr_q];
  assign bus.out_tag        = w_head_tag;
  assign bus.count          = count_q;
  assign bus.busy           = w_busy;
  assign bus.resp_underflow = resp_underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_vfu_request_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vfu_request_buffer
// Purpose  : Directed and random stimulus for vfu_request_buffer, checked
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vfu_request_buffer;

  localparam int DEPTH     = 4;
  localparam int PAYLOAD_W = 206;
  localparam int TAG_W     = 2;
  localparam int MAX_OUT   = 2;
  localparam int NTAGS     = 1 << TAG_W;

  typedef struct {
    logic [PAYLOAD_W-1:0] bits;
    logic [TAG_W-1:0]     tag;
  } req_t;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  vfu_request_buffer_if #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W), .TAG_W(TAG_W)) bus ();

  vfu_request_buffer #(
    .DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W), .TAG_W(TAG_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clock (clock),
    .reset (rst_n),
    .bus   (bus)
  );

  // Reference model state
  req_t q[$];
  int   cnt [NTAGS];
  bit   uf;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic bit m_out_valid();
    return (q.size() != 0) && (cnt[q[0].tag] != MAX_OUT);
  endfunction

  function automatic bit m_busy();
    bit b = 1'b0;
    for (int t = 0; t < NTAGS; t++) if (cnt[t] != 0) b = 1'b1;
    return b;
  endfunction

  function automatic logic [PAYLOAD_W-1:0] rnd_bits();
    logic [223:0] r;
    for (int i = 0; i < 7; i++) r[i*32 +: 32] = $urandom();
    return r[PAYLOAD_W-1:0];
  endfunction

  task automatic model_reset();
    q.delete();
    for (int t = 0; t < NTAGS; t++) cnt[t] = 0;
    uf = 1'b0;
  endtask

  task automatic compare_outputs();
    check("count", 256'(bus.count), 256'(q.size()));
    check("in_ready", 256'(bus.in_ready), 256'(q.size() < DEPTH));
    check("out_valid", 256'(bus.out_valid), 256'(m_out_valid()));
    if (m_out_valid()) begin
      check("out_tag", 256'(bus.out_tag), 256'(q[0].tag));
      check("out_bits", 256'(bus.out_bits), 256'(q[0].bits));
    end
    check("busy", 256'(bus.busy), 256'(m_busy()));
    check("resp_underflow", 256'(bus.resp_underflow), 256'(uf));
  endtask

  // One clock cycle: compare, drive, advance model; entered and left at a negedge
  task automatic step(input bit iv, input logic [PAYLOAD_W-1:0] ib, input logic [TAG_W-1:0] it,
                      input bit ordy, input bit rv, input logic [TAG_W-1:0] rt, input bit fl);
    bit push, pop, same;
    logic [TAG_W-1:0] ptag;
    req_t r;
    compare_outputs();
    bus.in_valid   = iv;
    bus.in_bits    = ib;
    bus.in_tag     = it;
    bus.out_ready  = ordy;
    bus.resp_valid = rv;
    bus.resp_tag   = rt;
    bus.flush      = fl;
    push = iv && (q.size() < DEPTH);
    pop  = m_out_valid() && ordy;
    ptag = pop ? q[0].tag : '0;
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        r.bits = ib;
        r.tag  = it;
        q.push_back(r);
      end
    end
    same = pop && !fl && rv && (rt == ptag);
    if (pop && !fl && !same) cnt[ptag]++;
    if (rv && !same) begin
      if (cnt[rt] == 0) uf = 1'b1;
      else              cnt[rt]--;
    end
    @(negedge clock);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Dispatch everything queued and complete everything in flight
  task automatic drain();
    int guard;
    bit rv;
    logic [TAG_W-1:0] rt;
    guard = 0;
    while ((q.size() != 0 || m_busy()) && guard < 200) begin
      rv = 1'b0;
      rt = '0;
      for (int t = 0; t < NTAGS; t++) begin
        if (!rv && cnt[t] != 0) begin
          rv = 1'b1;
          rt = t[TAG_W-1:0];
        end
      end
      step(1'b0, '0, '0, 1'b1, rv, rt, 1'b0);
      guard++;
    end
    if (guard >= 200) check("drain_timeout", 256'(guard), 256'(0));
  endtask

  // Hard time limit
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [PAYLOAD_W-1:0] b;
    bus.in_valid = 1'b0; bus.in_bits = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
    bus.resp_valid = 1'b0; bus.resp_tag = '0; bus.flush = 1'b0;
    model_reset();

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_in_ready", 256'(bus.in_ready), 256'(1));
    check("rst_out_valid", 256'(bus.out_valid), 256'(0));
    check("rst_busy", 256'(bus.busy), 256'(0));
    check("rst_count", 256'(bus.count), 256'(0));
    check("rst_underflow", 256'(bus.resp_underflow), 256'(0));
    rst_n = 1'b1;

    // Basic flow: one-cycle latency, then in flight
    b = rnd_bits();
    b[7:0] = 8'hA5;
    step(1'b1, b, 2'd1, 1'b1, 1'b0, '0, 1'b0);
    check("basic_out_valid", 256'(bus.out_valid), 256'(1));
    check("basic_out_tag", 256'(bus.out_tag), 256'(1));
    check("basic_out_bits", 256'(bus.out_bits), 256'(b));
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    check("basic_busy", 256'(bus.busy), 256'(1));
    drain();

    // Full: no push accepted while full, even with a concurrent pop
    for (int i = 0; i < 4; i++) step(1'b1, rnd_bits(), i[TAG_W-1:0], 1'b0, 1'b0, '0, 1'b0);
    check("full_count", 256'(bus.count), 256'(4));
    check("full_in_ready", 256'(bus.in_ready), 256'(0));
    step(1'b1, rnd_bits(), 2'd3, 1'b1, 1'b0, '0, 1'b0);
    check("full_pop_count", 256'(bus.count), 256'(3));
    drain();

    // Tag gating at MAX_OUT
    for (int i = 0; i < 3; i++) step(1'b1, rnd_bits(), 2'd2, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    check("gate_stalled", 256'(bus.out_valid), 256'(0));
    check("gate_count", 256'(bus.count), 256'(1));
    step(1'b0, '0, '0, 1'b1, 1'b1, 2'd2, 1'b0);
    check("gate_released", 256'(bus.out_valid), 256'(1));
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    check("gate_dispatched", 256'(bus.count), 256'(0));
    drain();

    // Same-tag pop and response in one cycle
    step(1'b1, rnd_bits(), 2'd0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, rnd_bits(), 2'd0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1, 2'd0, 1'b0);
    check("same_underflow", 256'(bus.resp_underflow), 256'(0));
    check("same_busy", 256'(bus.busy), 256'(1));
    for (int i = 0; i < 2; i++) step(1'b1, rnd_bits(), 2'd0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    check("same_counter_gates", 256'(bus.count), 256'(1));
    drain();

    // Underflow is sticky
    step(1'b0, '0, '0, 1'b0, 1'b1, 2'd3, 1'b0);
    check("uf_set", 256'(bus.resp_underflow), 256'(1));
    repeat (10) idle();
    check("uf_sticky", 256'(bus.resp_underflow), 256'(1));
    check("uf_counter_zero", 256'(bus.busy), 256'(0));

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, rnd_bits(), TAG_W'($urandom_range(0, NTAGS - 1)),
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
           TAG_W'($urandom_range(0, NTAGS - 1)), $urandom_range(0, 63) == 0);
    end
    drain();

    // Flush with one request in flight and three queued
    step(1'b1, rnd_bits(), 2'd1, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, rnd_bits(), 2'd2, 1'b0, 1'b0, '0, 1'b0);
    check("flush_pre_count", 256'(bus.count), 256'(3));
    step(1'b1, rnd_bits(), 2'd3, 1'b0, 1'b0, '0, 1'b1);
    check("flush_count", 256'(bus.count), 256'(0));
    check("flush_busy", 256'(bus.busy), 256'(1));
    check("flush_out_valid", 256'(bus.out_valid), 256'(0));
    idle();

    // Asynchronous reset mid-stream
    step(1'b1, rnd_bits(), 2'd0, 1'b0, 1'b0, '0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_bits  = rnd_bits();
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 256'(bus.count), 256'(0));
    check("arst_busy", 256'(bus.busy), 256'(0));
    check("arst_out_valid", 256'(bus.out_valid), 256'(0));
    check("arst_in_ready", 256'(bus.in_ready), 256'(1));
    model_reset();
    bus.in_valid = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step($urandom_range(0, 1) != 0, rnd_bits(), TAG_W'($urandom_range(0, NTAGS - 1)),
           1'b1, $urandom_range(0, 1) != 0, TAG_W'($urandom_range(0, NTAGS - 1)), 1'b0);
    end
    compare_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
